// File: rtl/dec_onehot_tracker_pkg.sv
// Shared types and helpers for the decoder one-hot tracker.
package dec_pkg;

    localparam int unsigned N_LINES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2
    } state_e;

    // Counts definite ones and zeros separately so any X/Z bit fails the test.
    function automatic logic is_onehot(input logic [N_LINES-1:0] w);
        int unsigned ones;
        int unsigned zeros;
        ones  = 0;
        zeros = 0;
        for (int unsigned i = 0; i < N_LINES; i++) begin
            if (w[i] == 1'b1) ones++;
            if (w[i] == 1'b0) zeros++;
        end
        return (ones == 1) && (zeros == N_LINES - 1);
    endfunction

endpackage

// File: rtl/dec_onehot_tracker_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/dec_onehot_tracker.sv
// Per-line hit counter for a one-hot decoder output, with error tracking
// and a drained, single-shot read port.
module dec_onehot_tracker #(
    parameter int unsigned N_LINES = dec_pkg::N_LINES,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_LINES-1:0] dec_word,
    input  logic               clr,
    input  logic               rd_req,
    input  logic [1:0]         rd_idx,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   rd_data,
    output logic               err_onehot,
    output logic [CNT_W-1:0]   err_cnt
);
    import dec_pkg::*;

    state_e               state;
    logic                 ready_en;
    logic                 s1_valid;
    logic [N_LINES-1:0]   s1_word;
    logic [1:0]           idx_q;
    logic [CNT_W-1:0]     rd_hold;
    logic [CNT_W-1:0]     cnt [N_LINES];
    logic                 accept;
    logic                 s1_hit;
    logic                 s1_miss;
    logic [N_LINES-1:0]   line_inc;

    // ready_en keeps in_ready low until the first edge after reset release
    assign in_ready = ready_en && (state == IDLE) && !clr;
    assign accept   = in_valid && in_ready;
    assign s1_hit   = s1_valid && is_onehot(s1_word);
    assign s1_miss  = s1_valid && !is_onehot(s1_word);

    always_comb begin
        line_inc = '0;
        if (s1_hit) line_inc = s1_word;
    end

    for (genvar i = 0; i < N_LINES; i++) begin : g_line
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (line_inc[i]),
            .clr   (clr),
            .q     (cnt[i])
        );
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (s1_miss),
        .clr   (clr),
        .q     (err_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            s1_valid   <= 1'b0;
            s1_word    <= '0;
            err_onehot <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            s1_valid <= accept;
            if (accept) s1_word <= dec_word;
            if (clr) begin
                err_onehot <= 1'b0;
            end else if (s1_miss) begin
                err_onehot <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx_q   <= '0;
            rd_hold <= '0;
        end else if (clr) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        idx_q <= rd_idx;
                        state <= s1_valid ? DRAIN : READ;
                    end
                end
                DRAIN: state <= READ;
                READ: begin
                    rd_hold <= cnt[idx_q];
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // clr in the READ cycle suppresses the pulse and leaves rd_data unchanged
    assign rd_valid = (state == READ) && !clr;
    assign rd_data  = rd_valid ? cnt[idx_q] : rd_hold;

endmodule

// File: tb/tb_dec_onehot_tracker.sv
// Directed self-checking bench for dec_onehot_tracker (built with CNT_W=4).
module tb_dec_onehot_tracker;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   dec_word;
    logic         clr;
    logic         rd_req;
    logic [1:0]   rd_idx;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic         err_onehot;
    logic [W-1:0] err_cnt;

    int total;
    int bad;

    dec_onehot_tracker #(.N_LINES(4), .CNT_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dec_word   (dec_word),
        .clr        (clr),
        .rd_req     (rd_req),
        .rd_idx     (rd_idx),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .err_onehot (err_onehot),
        .err_cnt    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] w);
        in_valid = 1'b1;
        dec_word = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Issues a read and waits a bounded number of cycles for rd_valid.
    task automatic do_read(input logic [1:0] idx, output logic [W-1:0] d, output bit seen);
        seen = 1'b0;
        d    = '0;
        rd_req = 1'b1;
        rd_idx = idx;
        tick();
        rd_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!seen) begin
                if (rd_valid) begin
                    d    = rd_data;
                    seen = 1'b1;
                end
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; dec_word = '0; clr = 1'b0; rd_req = 1'b0; rd_idx = '0;
        repeat (2) tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
        total++; if (err_onehot !== 1'b0) begin bad++; $display("FAIL reset_err_onehot got=%0b exp=0", err_onehot); end
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%0b exp=0", in_ready); end
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%0b exp=1", in_ready); end
    endtask

    task automatic test_stream();
        logic [W-1:0] d;
        bit s;
        send(4'b0001); send(4'b0010); send(4'b0001); send(4'b0100);
        do_read(2'd0, d, s);
        total++; if (!s || d !== 4'd2) begin bad++; $display("FAIL stream_cnt0 seen=%0b got=%0d exp=2", s, d); end
        do_read(2'd1, d, s);
        total++; if (!s || d !== 4'd1) begin bad++; $display("FAIL stream_cnt1 seen=%0b got=%0d exp=1", s, d); end
        do_read(2'd2, d, s);
        total++; if (!s || d !== 4'd1) begin bad++; $display("FAIL stream_cnt2 seen=%0b got=%0d exp=1", s, d); end
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL stream_err_cnt got=%0d exp=0", err_cnt); end
        total++; if (err_onehot !== 1'b0) begin bad++; $display("FAIL stream_err_onehot got=%0b exp=0", err_onehot); end
    endtask

    task automatic test_bad_words();
        logic [W-1:0] d;
        bit s;
        send(4'b0110); send(4'b0000);
        tick();
        total++; if (err_onehot !== 1'b1) begin bad++; $display("FAIL bad_err_onehot got=%0b exp=1", err_onehot); end
        total++; if (err_cnt !== 4'd2) begin bad++; $display("FAIL bad_err_cnt got=%0d exp=2", err_cnt); end
        do_read(2'd0, d, s);
        total++; if (!s || d !== 4'd2) begin bad++; $display("FAIL bad_cnt0 seen=%0b got=%0d exp=2", s, d); end
        do_read(2'd1, d, s);
        total++; if (!s || d !== 4'd1) begin bad++; $display("FAIL bad_cnt1 seen=%0b got=%0d exp=1", s, d); end
        do_read(2'd2, d, s);
        total++; if (!s || d !== 4'd1) begin bad++; $display("FAIL bad_cnt2 seen=%0b got=%0d exp=1", s, d); end
        do_read(2'd3, d, s);
        total++; if (!s || d !== 4'd0) begin bad++; $display("FAIL bad_cnt3 seen=%0b got=%0d exp=0", s, d); end
    endtask

    task automatic test_drain_read();
        pulse_clr();
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL clr_err_cnt got=%0d exp=0", err_cnt); end
        send(4'b0010);
        rd_req = 1'b1;
        rd_idx = 2'd1;
        tick();
        rd_req = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL drain_in_ready got=%0b exp=0", in_ready); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL drain_rd_valid got=%0b exp=0", rd_valid); end
        tick();
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL read_rd_valid got=%0b exp=1", rd_valid); end
        total++; if (rd_data !== 4'd1) begin bad++; $display("FAIL read_rd_data got=%0d exp=1", rd_data); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL read_in_ready got=%0b exp=0", in_ready); end
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL post_read_rd_valid got=%0b exp=0", rd_valid); end
        total++; if (rd_data !== 4'd1) begin bad++; $display("FAIL hold_rd_data got=%0d exp=1", rd_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_read_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_saturation();
        logic [W-1:0] d;
        bit s;
        pulse_clr();
        in_valid = 1'b1;
        dec_word = 4'b0001;
        repeat (20) tick();
        dec_word = 4'b1001;
        repeat (20) tick();
        in_valid = 1'b0;
        do_read(2'd0, d, s);
        total++; if (!s || d !== 4'd15) begin bad++; $display("FAIL sat_cnt0 seen=%0b got=%0d exp=15", s, d); end
        total++; if (err_cnt !== 4'd15) begin bad++; $display("FAIL sat_err_cnt got=%0d exp=15", err_cnt); end
        do_read(2'd3, d, s);
        total++; if (!s || d !== 4'd0) begin bad++; $display("FAIL sat_cnt3 seen=%0b got=%0d exp=0", s, d); end
    endtask

    task automatic test_clr_override();
        logic [W-1:0] d;
        bit s;
        bit pulse;
        pulse_clr();
        send(4'b0011); send(4'b0100); send(4'b0001);
        total++; if (err_onehot !== 1'b1) begin bad++; $display("FAIL pre_clr_err_onehot got=%0b exp=1", err_onehot); end
        clr = 1'b1; rd_req = 1'b1; rd_idx = 2'd0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clr_in_ready got=%0b exp=0", in_ready); end
        @(posedge clk); #1;
        clr = 1'b0; rd_req = 1'b0;
        pulse = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rd_valid) pulse = 1'b1;
            tick();
        end
        total++; if (pulse !== 1'b0) begin bad++; $display("FAIL clr_drop_read got=%0b exp=0", pulse); end
        total++; if (err_onehot !== 1'b0) begin bad++; $display("FAIL clr_err_onehot got=%0b exp=0", err_onehot); end
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL clr_err_cnt2 got=%0d exp=0", err_cnt); end
        for (int i = 0; i < 3; i++) begin
            do_read(2'(i), d, s);
            total++; if (!s || d !== 4'd0) begin bad++; $display("FAIL clr_cnt%0d seen=%0b got=%0d exp=0", i, s, d); end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [W-1:0] d;
        bit s;
        pulse_clr();
        send(4'b0001);
        tick();
        rd_req = 1'b1; rd_idx = 2'd0;
        tick();
        rd_req = 1'b0;
        total++; if (rd_valid !== 1'b1 || rd_data !== 4'd1) begin bad++; $display("FAIL mid_read v=%0b got=%0d exp=1", rd_valid, rd_data); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL async_rd_valid got=%0b exp=0", rd_valid); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL async_rd_data got=%0d exp=0", rd_data); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL async_in_ready got=%0b exp=0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rerelease_in_ready got=%0b exp=1", in_ready); end
        do_read(2'd0, d, s);
        total++; if (!s || d !== 4'd0) begin bad++; $display("FAIL after_reset_cnt0 seen=%0b got=%0d exp=0", s, d); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream();
        test_bad_words();
        test_drain_read();
        test_saturation();
        test_clr_override();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
